// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcodes, ALU operations,
// sequencer state encodings and default datapath widths.
package cpu_pkg;

  localparam int CPU_PC_W        = 8;
  localparam int CPU_INSTR_W     = 12;
  localparam int CPU_MEM_TIMEOUT = 15;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_SUBI = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_ORI  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_LDA  = 4'h7;
  localparam logic [3:0] OP_STA  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_ANDI = 4'hA;
  localparam logic [3:0] OP_NOP  = 4'hF;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_PASS = 3'b100;

  typedef enum logic [2:0] {
    SEQ_IDLE    = 3'd0,
    SEQ_FETCH   = 3'd1,
    SEQ_LOAD_IR = 3'd2,
    SEQ_DECODE  = 3'd3,
    SEQ_MEM     = 3'd4,
    SEQ_EXEC    = 3'd5,
    SEQ_FAULT   = 3'd6
  } seq_state_e;

endpackage

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute sequencer: owns PC and IR, turns control-unit levels into
// single-cycle strobes and a held data-memory request guarded by a timeout.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W        = CPU_PC_W,
  parameter int INSTR_W     = CPU_INSTR_W,
  parameter int MEM_TIMEOUT = CPU_MEM_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  output logic [3:0]         opcode,
  output logic [PC_W-1:0]    operand,
  input  logic               alu_en,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic               acc_write,
  input  logic               pc_load,
  input  logic               use_immed,
  output logic               mem_req,
  output logic               mem_we,
  input  logic               mem_ack,
  output logic               acc_we,
  output logic               busy,
  output logic               fault,
  output logic [2:0]         state
);

  localparam int               CNT_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_TIMEOUT - 1);

  seq_state_e          state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;

  seq_state_e          end_state;
  logic                needs_exec;

  // run is only consulted when an instruction retires (and in IDLE).
  assign end_state  = run ? SEQ_FETCH : SEQ_IDLE;
  // Immediate-operand instructions consume their operand in EXEC as well.
  assign needs_exec = acc_write | alu_en | use_immed;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      SEQ_IDLE:    if (run) state_d = SEQ_FETCH;
      SEQ_FETCH:   state_d = SEQ_LOAD_IR;
      SEQ_LOAD_IR: begin
        ir_d    = prog_data;
        state_d = SEQ_DECODE;
      end
      SEQ_DECODE: begin
        if (pc_load) begin
          pc_d    = operand;
          state_d = end_state;
        end else if (mem_read || mem_write) begin
          wait_cnt_d = '0;
          state_d    = SEQ_MEM;
        end else if (needs_exec) begin
          state_d = SEQ_EXEC;
        end else begin
          pc_d    = pc_q + PC_W'(1);
          state_d = end_state;
        end
      end
      SEQ_MEM: begin
        if (mem_ack) begin
          if (mem_write) begin
            pc_d    = pc_q + PC_W'(1);
            state_d = end_state;
          end else begin
            state_d = SEQ_EXEC;
          end
        end else if (wait_cnt_q == LAST_WAIT) begin
          state_d = SEQ_FAULT;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      SEQ_EXEC: begin
        pc_d    = pc_q + PC_W'(1);
        state_d = end_state;
      end
      SEQ_FAULT:   state_d = SEQ_FAULT;
      default:     state_d = SEQ_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SEQ_IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign prog_addr = pc_q;
  assign opcode    = ir_q[INSTR_W-1 -: 4];
  assign operand   = ir_q[PC_W-1:0];
  assign mem_req   = (state_q == SEQ_MEM);
  assign mem_we    = (state_q == SEQ_MEM) && mem_write;
  assign acc_we    = (state_q == SEQ_EXEC) && acc_write;
  assign busy      = (state_q != SEQ_IDLE) && (state_q != SEQ_FAULT);
  assign fault     = (state_q == SEQ_FAULT);
  assign state     = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: an instruction-phase model predicts every
// cycle's outputs, and each scenario pins key numbers with literal checks.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_DECODE = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_EXEC   = 3'd5;
  localparam logic [2:0] ST_FAULT  = 3'd6;
  localparam int         TIMEOUT   = 15;
  localparam int         NEVER     = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [7:0]  prog_addr;
  logic [11:0] prog_data = '0;
  logic [3:0]  opcode;
  logic [7:0]  operand;
  logic        alu_en, mem_read, mem_write, acc_write, pc_load, use_immed;
  logic        mem_req, mem_we, acc_we, busy, fault;
  logic        mem_ack = 1'b0;
  logic [2:0]  state;

  cpu_sequencer dut (
    .clk(clk), .rst(rst), .run(run),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .opcode(opcode), .operand(operand),
    .alu_en(alu_en), .mem_read(mem_read), .mem_write(mem_write),
    .acc_write(acc_write), .pc_load(pc_load), .use_immed(use_immed),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
    .acc_we(acc_we), .busy(busy), .fault(fault), .state(state)
  );

  initial forever #5 clk = ~clk;

  // Program ROM with one cycle of read latency.
  logic [11:0] rom [256];
  always @(posedge clk) prog_data <= rom[prog_addr];

  // Sibling control unit: decode levels from the presented opcode.
  always_comb begin
    {alu_en, mem_read, mem_write, acc_write, pc_load, use_immed} = '0;
    case (opcode)
      OP_ADD, OP_SUB, OP_OR, OP_AND: begin
        mem_read = 1'b1; alu_en = 1'b1; acc_write = 1'b1;
      end
      OP_ADDI, OP_SUBI, OP_ORI, OP_ANDI: begin
        alu_en = 1'b1; acc_write = 1'b1; use_immed = 1'b1;
      end
      OP_LDA: begin mem_read = 1'b1; acc_write = 1'b1; end
      OP_STA: mem_write = 1'b1;
      OP_JMP: pc_load = 1'b1;
      default: ;
    endcase
  end

  // Data RAM responder: acks after ack_delay wait cycles; stray_ack drives ack outside requests.
  int ack_delay = 0;
  bit stray_ack = 1'b0;
  int req_age   = 0;
  always @(negedge clk) begin
    if (mem_req) begin
      mem_ack = (req_age == ack_delay);
      req_age++;
    end else begin
      mem_ack = stray_ack;
      req_age = 0;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected per-cycle output record, in the same field order as the compare concatenation.
  typedef struct packed {
    logic [2:0] st;
    logic [7:0] pc;
    logic [3:0] opc;
    logic [7:0] opnd;
    logic       req;
    logic       we;
    logic       accwe;
    logic       busy;
    logic       flt;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  m_pc = '0;
  logic [11:0] m_ir = '0;

  task automatic push(input logic [2:0] st, input logic req, input logic we, input logic accwe);
    exp_t e;
    e.st    = st;
    e.pc    = m_pc;
    e.opc   = m_ir[11:8];
    e.opnd  = m_ir[7:0];
    e.req   = req;
    e.we    = we;
    e.accwe = accwe;
    e.busy  = (st != ST_IDLE) && (st != ST_FAULT);
    e.flt   = (st == ST_FAULT);
    exp_q.push_back(e);
  endtask

  task automatic gen_idle(input int n);
    repeat (n) push(ST_IDLE, 1'b0, 1'b0, 1'b0);
  endtask

  // One instruction from m_pc; delay = wait cycles before ack (>= TIMEOUT means no ack).
  task automatic gen_instr(input int delay);
    logic [3:0] op;
    int         n_mem;
    push(ST_FETCH, 1'b0, 1'b0, 1'b0);
    push(ST_LOAD, 1'b0, 1'b0, 1'b0);
    m_ir = rom[m_pc];
    op   = m_ir[11:8];
    push(ST_DECODE, 1'b0, 1'b0, 1'b0);
    if (op == OP_JMP) begin
      m_pc = m_ir[7:0];
    end else if (op inside {OP_ADD, OP_SUB, OP_OR, OP_AND, OP_LDA, OP_STA}) begin
      n_mem = (delay < TIMEOUT) ? delay + 1 : TIMEOUT;
      repeat (n_mem) push(ST_MEM, 1'b1, op == OP_STA, 1'b0);
      if (delay >= TIMEOUT) begin
        repeat (6) push(ST_FAULT, 1'b0, 1'b0, 1'b0);
        return;
      end
      if (op != OP_STA) push(ST_EXEC, 1'b0, 1'b0, 1'b1);
      m_pc = m_pc + 8'd1;
    end else if (op inside {OP_ADDI, OP_SUBI, OP_ORI, OP_ANDI}) begin
      push(ST_EXEC, 1'b0, 1'b0, 1'b1);
      m_pc = m_pc + 8'd1;
    end else begin
      m_pc = m_pc + 8'd1;
    end
  endtask

  int cyc     = 0;
  int n_busy  = 0;
  int n_req   = 0;
  int n_we    = 0;
  int n_accwe = 0;

  initial begin : compare
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (busy)    n_busy++;
      if (mem_req) n_req++;
      if (mem_we)  n_we++;
      if (acc_we)  n_accwe++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check($sformatf("trace cyc%0d {st,pc,op,opnd,req,we,accwe,busy,flt}", cyc),
              32'({state, prog_addr, opcode, operand, mem_req, mem_we, acc_we, busy, fault}),
              32'(e));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 256; i++) rom[i] = 12'hF00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    run = 1'b0;
    @(negedge clk);
    rst       = 1'b0;
    stray_ack = 1'b0;
    m_pc      = '0;
    m_ir      = '0;
    n_busy    = 0;
    n_req     = 0;
    n_we      = 0;
    n_accwe   = 0;
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    check("trace drained (entries left)", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    rom_clear();

    // ADDI 0x05 then NOP; run dropped during the NOP.
    do_reset();
    rom[0] = 12'h105;
    ack_delay = 0;
    run = 1'b1;
    gen_instr(0);
    gen_instr(0);
    gen_idle(2);
    cycles(3);
    check("addi: state in cycle 3", state, ST_DECODE);
    cycles(1);
    check("addi: acc_we in cycle 4", acc_we, 1);
    cycles(1);
    check("addi: state back to FETCH", state, ST_FETCH);
    check("addi: pc after ADDI", prog_addr, 8'h01);
    cycles(1);
    run = 1'b0;
    drain();
    check("addi: acc_we pulses", n_accwe, 1);
    check("addi: parked pc", prog_addr, 8'h02);

    // LDA 0x20, ack after 3 wait cycles; run dropped in DECODE.
    do_reset();
    rom_clear();
    rom[0] = 12'h720;
    ack_delay = 3;
    run = 1'b1;
    gen_instr(3);
    gen_idle(2);
    cycles(3);
    run = 1'b0;
    drain();
    check("lda: mem_req cycles", n_req, 4);
    check("lda: mem_we cycles", n_we, 0);
    check("lda: acc_we pulses", n_accwe, 1);
    check("lda: busy cycles", n_busy, 8);
    check("lda: pc", prog_addr, 8'h01);

    // STA 0x10, ack in first MEM cycle, stray acks elsewhere.
    do_reset();
    rom_clear();
    rom[0] = 12'h810;
    ack_delay = 0;
    stray_ack = 1'b1;
    run = 1'b1;
    gen_instr(0);
    gen_idle(2);
    cycles(2);
    run = 1'b0;
    drain();
    check("sta: mem_req cycles", n_req, 1);
    check("sta: mem_we cycles", n_we, 1);
    check("sta: acc_we pulses", n_accwe, 0);
    check("sta: pc", prog_addr, 8'h01);

    // JMP 0xFF then NOP at 0xFF: pc wraps to 0x00.
    do_reset();
    rom_clear();
    rom[0] = 12'h9FF;
    run = 1'b1;
    gen_instr(0);
    gen_instr(0);
    gen_idle(2);
    cycles(4);
    check("jmp: prog_addr after jump", prog_addr, 8'hFF);
    run = 1'b0;
    drain();
    check("jmp: pc wrapped", prog_addr, 8'h00);
    check("jmp: parked state", state, ST_IDLE);

    // LDA acked in the last allowed wait cycle: no fault.
    do_reset();
    rom_clear();
    rom[0] = 12'h720;
    ack_delay = TIMEOUT - 1;
    run = 1'b1;
    gen_instr(TIMEOUT - 1);
    gen_idle(2);
    cycles(3);
    run = 1'b0;
    drain();
    check("late ack: mem_req cycles", n_req, 15);
    check("late ack: fault", fault, 0);
    check("late ack: acc_we pulses", n_accwe, 1);
    check("late ack: pc", prog_addr, 8'h01);

    // NOP then LDA that is never acked: FAULT after 15 MEM cycles.
    do_reset();
    rom_clear();
    rom[1] = 12'h720;
    ack_delay = NEVER;
    stray_ack = 1'b1;
    run = 1'b1;
    gen_instr(0);
    gen_instr(NEVER);
    drain();
    check("timeout: mem_req cycles", n_req, 15);
    check("timeout: fault", fault, 1);
    check("timeout: busy", busy, 0);
    check("timeout: frozen pc", prog_addr, 8'h01);
    cycles(3);
    check("timeout: still FAULT", state, ST_FAULT);
    do_reset();
    check("timeout: fault after rst", fault, 0);
    check("timeout: pc after rst", prog_addr, 8'h00);
    check("timeout: state after rst", state, ST_IDLE);

    // ADD with run dropped during MEM: completes, parks in IDLE.
    do_reset();
    rom_clear();
    rom[0] = 12'h030;
    ack_delay = 2;
    run = 1'b1;
    gen_instr(2);
    gen_idle(2);
    cycles(5);
    check("add: in MEM when run drops", state, ST_MEM);
    run = 1'b0;
    drain();
    check("add: acc_we pulses", n_accwe, 1);
    check("add: parked state", state, ST_IDLE);
    check("add: parked pc", prog_addr, 8'h01);

    // rst while mem_req is high.
    do_reset();
    rom_clear();
    rom[0] = 12'h720;
    ack_delay = NEVER;
    run = 1'b1;
    gen_instr(NEVER);
    cycles(5);
    check("rst in MEM: mem_req before rst", mem_req, 1);
    rst = 1'b1;
    exp_q.delete();
    cycles(1);
    check("rst in MEM: state", state, ST_IDLE);
    check("rst in MEM: mem_req", mem_req, 0);
    check("rst in MEM: pc", prog_addr, 8'h00);
    check("rst in MEM: opcode", opcode, 4'h0);
    check("rst in MEM: operand", operand, 8'h00);
    check("rst in MEM: busy", busy, 0);
    check("rst in MEM: acc_we", acc_we, 0);
    rst = 1'b0;
    run = 1'b0;
    cycles(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
